paddle_motion: RTL and testbench
================================

# paddle_motion

Frame-rate motion controller for one vertical Pong paddle. It produces the paddle centre position and half-height consumed by `paddle_mapper`, which turns them into per-pixel coverage. Once per frame it samples two direction keys, ramps a per-frame speed, and advances the paddle's Y centre. The result is clamped so the paddle never leaves the visible area.

## Interface

Parameters:
- PADDLE_X, 40: fixed X centre (pixels).
- Y_CENTER, 240: reset Y centre.
- Y_MIN, 0: topmost visible row.
- Y_MAX, 479: bottommost visible row.
- PADDLE_SIZE, 24: half-height (pixels); driven on PaddleSize.
- MAX_SPEED, 4: speed cap (pixels/frame), 1..15.

Ports:
- Clk  in  1  system clock; all state on its rising edge.
- Reset  in  1  asynchronous, active-high reset.
- frame_clk  in  1  frame strobe (VGA vsync), synchronous to Clk.
- up_key  in  1  level, move toward smaller Y.
- down_key  in  1  level, move toward larger Y.
- PaddleX  out  10  constant PADDLE_X.
- PaddleY  out  10  registered Y centre.
- PaddleSize  out  10  constant PADDLE_SIZE.
- moving  out  1  registered; high when speed ≠ 0.

## Operation

- Edge detect:
  - Register frame_clk_d ← frame_clk.
  - frame_tick = frame_clk & ~frame_clk_d.
  - All motion state changes only in a frame_tick cycle. Otherwise it holds.
- Direction FSM: IDLE, UP, DOWN, plus a 4-bit speed register.
  - Key decode at tick: cmd = UP if up_key & ~down_key; DOWN if down_key & ~up_key; else NONE.
  - cmd NONE: go to IDLE, speed ← 0.
  - cmd equals current direction: speed ← min(speed+1, MAX_SPEED).
  - cmd opposite to current direction, or state is IDLE: state ← cmd, speed ← 1. There is no deceleration phase on reversal.
- Position update, same tick, using the new speed:
  - Compute in 11-bit signed: Ynext = PaddleY ± speed.
  - Lower bound LO = Y_MIN + PADDLE_SIZE. Upper bound HI = Y_MAX − PADDLE_SIZE.
  - If Ynext < LO: PaddleY ← LO, speed ← 0, state ← IDLE.
  - If Ynext > HI: PaddleY ← HI, speed ← 0, state ← IDLE.
  - Otherwise PaddleY ← Ynext.
  - No unsigned wrap is permitted at either end.
- Key held against a wall: each tick re-enters the direction with speed 1, clamps, and returns to IDLE. PaddleY stays at the bound and moving stays low.
- moving = (speed ≠ 0) after the tick's update.

## Timing

- Reset (asynchronous, immediate), all outputs and state:
  - PaddleY = Y_CENTER, speed = 0, state = IDLE, moving = 0.
  - frame_clk_d = 1, so no spurious tick if frame_clk is high when Reset releases.
  - PaddleX and PaddleSize are constants at all times.
- Latency:
  - The tick is decoded in the Clk cycle where frame_clk first reads 1.
  - PaddleY and moving take their new values at the Clk edge ending that cycle.
  - Keys are sampled only in the tick cycle. Key changes between ticks are ignored.
- Exactly one update per frame_clk rising edge, regardless of high-time length.
- Reset asserted mid-frame or mid-ramp returns everything to reset values at once.
- After Reset releases, motion resumes at the next frame_clk rising edge.
- Outputs are stable for the whole frame between ticks. This is safe for the `paddle_mapper` pixel scan.

## Test plan

- Reset ramp:
  - Stimulus: Reset, then down_key held for 3 frame_clk edges.
  - Required: PaddleY 241, 243, 246; moving = 1 after the first tick.
  - Required: PaddleY unchanged between ticks, even with frame_clk held high 100 cycles.
- Speed cap:
  - Stimulus: up_key held 6 ticks from Y=240.
  - Required: speeds 1,2,3,4,4,4; PaddleY 239, 237, 234, 230, 226, 222.
- Wall clamp:
  - Stimulus: down_key held until the bottom is reached, then 5 more ticks.
  - Required: PaddleY = 455 exactly, never above; moving = 0 and PaddleY = 455 on every further tick.
  - Stimulus: repeat upward.
  - Required: PaddleY = 24.
- Reversal and conflict:
  - Stimulus: ramp DOWN to speed 3, then up_key only.
  - Required: next tick PaddleY decreases by 1.
  - Stimulus: then both keys pressed.
  - Required: moving = 0, PaddleY unchanged.
- Async reset mid-move:
  - Stimulus: Reset pulsed between Clk edges while moving at speed 4.
  - Required: PaddleY = 240 and moving = 0 before the next Clk edge.
  - Stimulus: release Reset while frame_clk is high.
  - Required: no update until the next rising edge.

Source files
------------

// File: rtl/paddle_motion.sv
// paddle_motion: once-per-frame direction/speed ramp and clamped Y centre for
// one vertical Pong paddle. All motion state advances only on the Clk cycle in
// which a rising edge of frame_clk is first seen, so outputs hold for a frame.
module paddle_motion #(
    parameter int PADDLE_X    = 40,
    parameter int Y_CENTER    = 240,
    parameter int Y_MIN       = 0,
    parameter int Y_MAX       = 479,
    parameter int PADDLE_SIZE = 24,
    parameter int MAX_SPEED   = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       up_key,
    input  logic       down_key,
    output logic [9:0] PaddleX,
    output logic [9:0] PaddleY,
    output logic [9:0] PaddleSize,
    output logic       moving
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_UP   = 2'd1;
    localparam logic [1:0] ST_DOWN = 2'd2;

    // Centre may only range over rows that keep the whole paddle visible.
    localparam logic signed [10:0] Y_LO    = 11'(Y_MIN + PADDLE_SIZE);
    localparam logic signed [10:0] Y_HI    = 11'(Y_MAX - PADDLE_SIZE);
    localparam logic [3:0]         SPD_CAP = 4'(MAX_SPEED);

    logic              frame_clk_q, frame_clk_d;
    logic [1:0]        state_q, state_d;
    logic [3:0]        speed_q, speed_d;
    logic [9:0]        y_q, y_d;
    logic              moving_q, moving_d;

    logic              frame_tick;
    logic [1:0]        cmd;
    logic [3:0]        spd_new;
    logic signed [10:0] y_cur, step, y_next;

    // Next-state: edge detect, key decode, speed ramp, position step and clamp.
    always_comb begin
        frame_clk_d = frame_clk;
        frame_tick  = frame_clk & ~frame_clk_q;
        state_d     = state_q;
        speed_d     = speed_q;
        y_d         = y_q;
        moving_d    = moving_q;
        spd_new     = speed_q;
        y_cur       = $signed({1'b0, y_q});
        step        = '0;
        y_next      = y_cur;

        if (up_key & ~down_key)      cmd = ST_UP;
        else if (down_key & ~up_key) cmd = ST_DOWN;
        else                         cmd = ST_IDLE;

        if (frame_tick) begin
            // Reversal restarts at speed 1 with no deceleration phase.
            if (cmd == ST_IDLE) begin
                state_d = ST_IDLE;
                spd_new = 4'd0;
            end else if (cmd == state_q) begin
                spd_new = (speed_q >= SPD_CAP) ? SPD_CAP : speed_q + 4'd1;
            end else begin
                state_d = cmd;
                spd_new = 4'd1;
            end

            // Signed arithmetic so a step past row 0 cannot wrap to a large value.
            step   = $signed({7'd0, spd_new});
            y_next = (cmd == ST_UP) ? y_cur - step : y_cur + step;

            if (y_next < Y_LO) begin
                y_next  = Y_LO;
                spd_new = 4'd0;
                state_d = ST_IDLE;
            end else if (y_next > Y_HI) begin
                y_next  = Y_HI;
                spd_new = 4'd0;
                state_d = ST_IDLE;
            end

            speed_d  = spd_new;
            y_d      = y_next[9:0];
            moving_d = (spd_new != 4'd0);
        end
    end

    // State registers; frame_clk_q resets high so a held-high strobe at release is not a tick.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            frame_clk_q <= 1'b1;
            state_q     <= ST_IDLE;
            speed_q     <= 4'd0;
            y_q         <= 10'(Y_CENTER);
            moving_q    <= 1'b0;
        end else begin
            frame_clk_q <= frame_clk_d;
            state_q     <= state_d;
            speed_q     <= speed_d;
            y_q         <= y_d;
            moving_q    <= moving_d;
        end
    end

    assign PaddleX    = 10'(PADDLE_X);
    assign PaddleY    = y_q;
    assign PaddleSize = 10'(PADDLE_SIZE);
    assign moving     = moving_q;

endmodule

// File: tb/tb_paddle_motion.sv
// Scoreboard bench for paddle_motion: stimulus pushes the expected paddle state
// for each frame strobe; a monitor pops it one cycle later and otherwise checks
// that outputs hold their last value between strobes.
module tb_paddle_motion;

    localparam int LO  = 24;
    localparam int HI  = 455;
    localparam int CAP = 4;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_clk = 1'b0;
    logic       up_key = 1'b0;
    logic       down_key = 1'b0;
    logic [9:0] PaddleX, PaddleY, PaddleSize;
    logic       moving;

    paddle_motion dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
        .up_key(up_key), .down_key(down_key),
        .PaddleX(PaddleX), .PaddleY(PaddleY), .PaddleSize(PaddleSize),
        .moving(moving)
    );

    always #5 Clk = ~Clk;

    typedef struct { int y; bit mv; } exp_t;
    exp_t sb[$];
    int   held_y  = 240;
    bit   held_mv = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: direction as -1/0/+1 and speed as a plain integer.
    int m_y = 240, m_dir = 0, m_spd = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_y = 240; m_dir = 0; m_spd = 0;
        held_y = 240; held_mv = 1'b0;
        sb.delete();
    endtask

    function automatic exp_t model_tick(input bit up, input bit dn);
        exp_t e;
        int cmd, ny;
        cmd = (up && !dn) ? -1 : (dn && !up) ? 1 : 0;
        if (cmd == 0) begin
            m_dir = 0; m_spd = 0;
        end else if (cmd == m_dir) begin
            m_spd = (m_spd + 1 > CAP) ? CAP : m_spd + 1;
        end else begin
            m_dir = cmd; m_spd = 1;
        end
        ny = m_y + cmd * m_spd;
        if (ny < LO) begin
            m_y = LO; m_spd = 0; m_dir = 0;
        end else if (ny > HI) begin
            m_y = HI; m_spd = 0; m_dir = 0;
        end else begin
            m_y = ny;
        end
        e.y = m_y; e.mv = (m_spd != 0);
        return e;
    endfunction

    // One frame: keys set with the strobe's rising edge, strobe held hi cycles,
    // then lo cycles low with the keys scrambled (they must be ignored).
    task automatic tick(input bit up, input bit dn, input int hi, input int lo);
        @(negedge Clk); #1;
        up_key = up; down_key = dn; frame_clk = 1'b1;
        sb.push_back(model_tick(up, dn));
        repeat (hi) @(negedge Clk);
        #1 frame_clk = 1'b0;
        up_key = 1'($urandom); down_key = 1'($urandom);
        repeat (lo) @(negedge Clk);
    endtask

    task automatic do_reset();
        @(negedge Clk); #1;
        Reset = 1'b1; frame_clk = 1'b0;
        model_reset();
        repeat (2) @(negedge Clk);
        #1 Reset = 1'b0;
        @(negedge Clk);
    endtask

    // Monitor: a pending expectation is consumed one negedge after its strobe.
    always @(negedge Clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            held_y = e.y; held_mv = e.mv;
        end
        check("PaddleY", int'(PaddleY), held_y);
        check("moving", int'(moving), int'(held_mv));
        check("PaddleX", int'(PaddleX), 40);
        check("PaddleSize", int'(PaddleSize), 24);
        if (int'(PaddleY) > HI || int'(PaddleY) < LO) check("PaddleY_in_bounds", int'(PaddleY), held_y);
    end

    initial begin
        model_reset();
        repeat (3) @(negedge Clk);
        #1 Reset = 1'b0;
        @(negedge Clk);

        // Ramp down from centre: 241, 243, 246; last strobe held high 100 cycles.
        tick(0, 1, 1, 2);
        tick(0, 1, 1, 2);
        tick(0, 1, 100, 3);
        check("ramp_y", int'(PaddleY), 246);

        // Up ramp to the cap: 239, 237, 234, 230, 226, 222.
        do_reset();
        repeat (6) tick(1, 0, 1, 2);
        check("cap_y", int'(PaddleY), 222);

        // Bottom wall, then pressing into it.
        do_reset();
        repeat (70) tick(0, 1, 1, 1);
        check("bottom_y", int'(PaddleY), HI);
        check("bottom_moving", int'(moving), 0);
        // Top wall.
        repeat (130) tick(1, 0, 1, 1);
        check("top_y", int'(PaddleY), LO);
        check("top_moving", int'(moving), 0);

        // Reversal at speed 3 steps back by exactly 1; both keys stop.
        do_reset();
        repeat (3) tick(0, 1, 1, 2);
        tick(1, 0, 1, 2);
        check("reverse_y", int'(PaddleY), 245);
        tick(1, 1, 1, 2);
        check("conflict_y", int'(PaddleY), 245);
        check("conflict_moving", int'(moving), 0);

        // Async reset between edges while moving at speed 4.
        do_reset();
        repeat (5) tick(0, 1, 1, 2);
        check("pre_reset_moving", int'(moving), 1);
        @(posedge Clk); #2;
        Reset = 1'b1;
        model_reset();
        #1;
        check("async_rst_y", int'(PaddleY), 240);
        check("async_rst_moving", int'(moving), 0);
        // Release with the strobe already high: no update until the next rise.
        @(negedge Clk); #1;
        frame_clk = 1'b1; down_key = 1'b1;
        @(negedge Clk); #1;
        Reset = 1'b0;
        repeat (5) @(negedge Clk);
        #1 frame_clk = 1'b0;
        repeat (2) @(negedge Clk);
        check("release_hold_y", int'(PaddleY), 240);
        tick(0, 1, 1, 2);
        check("release_first_y", int'(PaddleY), 241);

        // Randomised frames: biased towards held keys so ramps and walls occur.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            int r;
            bit up, dn;
            r = int'($urandom_range(0, 9));
            up = (r < 4) || (r == 9);
            dn = ((r >= 4) && (r < 8)) || (r == 9);
            tick(up, dn, int'($urandom_range(1, 4)), int'($urandom_range(1, 4)));
        end

        @(negedge Clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
